// File: rtl/axi4_pkg.sv
// Shared encodings, FSM state type and the 4KB-boundary helper for the AXI4 read engine.
package axi4_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    RD_IDLE,
    RD_BURST
  } rd_state_e;

  // True when an INCR burst of (len+1) beats of 2^size bytes leaves its starting 4KB page.
  function automatic logic crosses_4k(input logic [31:0] start_addr,
                                      input logic [7:0]  len,
                                      input logic [2:0]  size);
    logic [31:0] last_addr;
    last_addr = start_addr + (({24'd0, len} + 32'd1) << size) - 32'd1;
    return last_addr[31:12] != start_addr[31:12];
  endfunction

endpackage

// File: rtl/axi4_rd_engine_if.sv
// AXI4 read channels plus the single-port memory read path, grouped for the read engine.
interface axi4_rd_engine_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int AXI_ADDR_WIDTH = 16,
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int ID_WIDTH       = 4
);
  logic [ID_WIDTH-1:0]       arid;
  logic [AXI_ADDR_WIDTH-1:0] araddr;
  logic [7:0]                arlen;
  logic [2:0]                arsize;
  logic [1:0]                arburst;
  logic                      arvalid;
  logic                      arready;
  logic [ID_WIDTH-1:0]       rid;
  logic [DATA_WIDTH-1:0]     rdata;
  logic [1:0]                rresp;
  logic                      rlast;
  logic                      rvalid;
  logic                      rready;
  logic                      mem_en;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]     mem_rdata;

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready, mem_rdata,
    output arready, rid, rdata, rresp, rlast, rvalid, mem_en, mem_addr
  );

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready, mem_rdata,
    input  arready, rid, rdata, rresp, rlast, rvalid, mem_en, mem_addr
  );
endinterface

// File: rtl/axi4_rd_skid.sv
// Two-entry FIFO holding {data,resp,last} R beats; head is presented directly on the R channel.
module axi4_rd_skid #(
  parameter int WIDTH = 35
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [1:0]       count_o
);
  logic [WIDTH-1:0] buf_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q, count_d;
  logic             pop;

  assign valid_o = (count_q != 2'd0);
  assign pop     = valid_o & ready_i;
  assign count_d = count_q + {1'b0, push_i} - {1'b0, pop};
  assign data_o  = buf_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      count_q <= count_d;
      if (push_i) wr_ptr_q <= ~wr_ptr_q;
      if (pop)    rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Payload storage needs no reset: nothing reads it while count_q is zero.
  always_ff @(posedge clk) begin
    if (push_i) buf_q[wr_ptr_q] <= push_data_i;
  end
endmodule

// File: rtl/axi4_rd_engine.sv
// AXI4 read front end for a word-addressed memory with 1-cycle read latency.
// Define AXI_RD_WRAP_EN to accept WRAP bursts; otherwise they complete as SLVERR.
module axi4_rd_engine
  import axi4_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int AXI_ADDR_WIDTH = 16,
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int DEPTH          = 1024,
  parameter int ID_WIDTH       = 4
) (
  input logic             clk,
  input logic             rst_n,
  axi4_rd_engine_if.slave axi
);
  localparam logic [2:0] SIZE_CODE = 3'($clog2(DATA_WIDTH/8));
  localparam int         SKW       = DATA_WIDTH + 3;
  localparam int         LWW       = MEM_ADDR_WIDTH + 9;

  rd_state_e                 state_q, state_d;
  logic                      arready_q, arready_d;
  logic [ID_WIDTH-1:0]       id_q;
  logic                      err_q;
  logic [1:0]                burst_q;
  logic [MEM_ADDR_WIDTH-1:0] cur_addr_q, mem_addr_q, wrap_mask_q, next_addr;
  logic [8:0]                left_q;
  logic                      inflight_q, inflight_last_q;

  logic                      ar_hs, ar_err, pop, can_issue, mem_en, err_push, push;
  logic [MEM_ADDR_WIDTH-1:0] ar_word;
  logic [LWW-1:0]            ar_last_word;
  logic [2:0]                outstanding;
  logic [SKW-1:0]            push_data, sk_head;
  logic                      sk_valid, sk_last;
  logic [1:0]                sk_count, sk_resp;
  logic [DATA_WIDTH-1:0]     sk_data;

  assign ar_hs   = axi.arvalid & arready_q;
  assign ar_word = axi.araddr[MEM_ADDR_WIDTH+1:2];

  always_comb begin
    ar_err       = (axi.arsize != SIZE_CODE);
    ar_last_word = {9'd0, ar_word};
    case (axi.arburst)
      BURST_FIXED: ;
      BURST_INCR: begin
        ar_last_word = {9'd0, ar_word} + {{(MEM_ADDR_WIDTH+1){1'b0}}, axi.arlen};
        if (crosses_4k(32'(axi.araddr) & ~32'd3, axi.arlen, SIZE_CODE)) ar_err = 1'b1;
      end
      BURST_WRAP: begin
`ifdef AXI_RD_WRAP_EN
        if (!(axi.arlen == 8'd1 || axi.arlen == 8'd3 || axi.arlen == 8'd7 || axi.arlen == 8'd15)
            || axi.araddr[1:0] != 2'b00) ar_err = 1'b1;
        ar_last_word = {9'd0, ar_word | MEM_ADDR_WIDTH'(axi.arlen)};
`else
        ar_err = 1'b1;
`endif
      end
      default: ar_err = 1'b1;
    endcase
    if (ar_last_word > LWW'(DEPTH - 1)) ar_err = 1'b1;
  end

  // Credit check counts the beat leaving this cycle so a streaming burst has no bubbles.
  always_comb begin
    pop         = sk_valid & axi.rready;
    outstanding = {2'b00, inflight_q} + {1'b0, sk_count} - {2'b00, pop};
    can_issue   = (state_q == RD_BURST) && (left_q != 9'd0) && (outstanding < 3'd2);
    mem_en      = can_issue & ~err_q;
    err_push    = can_issue & err_q;
    push        = inflight_q | err_push;
    push_data   = inflight_q ? {axi.mem_rdata, RESP_OKAY, inflight_last_q}
                             : {{DATA_WIDTH{1'b0}}, RESP_SLVERR, left_q == 9'd1};
    case (burst_q)
      BURST_INCR: next_addr = cur_addr_q + 1'b1;
      BURST_WRAP: next_addr = (cur_addr_q & ~wrap_mask_q) | ((cur_addr_q + 1'b1) & wrap_mask_q);
      default:    next_addr = cur_addr_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RD_IDLE:  if (ar_hs) state_d = RD_BURST;
      RD_BURST: if (pop && sk_last) state_d = RD_IDLE;
      default:  state_d = RD_IDLE;
    endcase
    arready_d = (state_d == RD_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= RD_IDLE;
      arready_q       <= 1'b0;
      id_q            <= '0;
      err_q           <= 1'b0;
      burst_q         <= BURST_FIXED;
      cur_addr_q      <= '0;
      mem_addr_q      <= '0;
      wrap_mask_q     <= '0;
      left_q          <= 9'd0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      arready_q  <= arready_d;
      inflight_q <= mem_en;
      if (mem_en) begin
        inflight_last_q <= (left_q == 9'd1);
        mem_addr_q      <= cur_addr_q;
      end
      if (ar_hs) begin
        id_q        <= axi.arid;
        err_q       <= ar_err;
        burst_q     <= axi.arburst;
        cur_addr_q  <= ar_word;
        wrap_mask_q <= MEM_ADDR_WIDTH'(axi.arlen);
        left_q      <= {1'b0, axi.arlen} + 9'd1;
      end else if (can_issue) begin
        left_q     <= left_q - 9'd1;
        cur_addr_q <= next_addr;
      end
    end
  end

  axi4_rd_skid #(.WIDTH(SKW)) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (push_data),
    .ready_i     (axi.rready),
    .valid_o     (sk_valid),
    .data_o      (sk_head),
    .count_o     (sk_count)
  );

  assign {sk_data, sk_resp, sk_last} = sk_head;

  assign axi.arready  = arready_q;
  assign axi.mem_en   = mem_en;
  assign axi.mem_addr = mem_en ? cur_addr_q : mem_addr_q;
  assign axi.rvalid   = sk_valid;
  assign axi.rdata    = sk_valid ? sk_data : '0;
  assign axi.rresp    = sk_valid ? sk_resp : RESP_OKAY;
  assign axi.rlast    = sk_valid & sk_last;
  assign axi.rid      = sk_valid ? id_q : '0;
endmodule

// File: tb/tb_axi4_rd_engine.sv
// Scoreboard bench for axi4_rd_engine: a burst-level reference model fills expected queues,
// an independent negedge monitor pops and compares R beats and memory accesses.
module tb_axi4_rd_engine;
  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi4_rd_engine_if bus ();
  axi4_rd_engine dut (.clk(clk), .rst_n(rst_n), .axi(bus));

  int          checks = 0;
  int          errors = 0;
  int          rr_mode = 0;
  int          beats_seen = 0;
  logic [31:0] mem_model [1024];
  beat_t       exp_q [$];
  int          exp_addr_q [$];

  always @(posedge clk) if (bus.mem_en) bus.mem_rdata <= mem_model[bus.mem_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Reference model: expected word addresses and beats for one burst, from the burst rules.
  function automatic void model_burst(input logic [3:0] id, input int addr, input int len,
                                      input int size, input int burst);
    int  word = (addr / 4) % 1024;
    int  a, base;
    bit  err = (size != 2) || (burst == 3);
    if (burst == 1) begin
      if (word + len > 1023) err = 1;
      if (((addr & ~3) / 4096) != (((addr & ~3) + (len + 1) * 4 - 1) / 4096)) err = 1;
    end
    if (burst == 2) begin
`ifdef AXI_RD_WRAP_EN
      if (!(len == 1 || len == 3 || len == 7 || len == 15) || (addr % 4) != 0) err = 1;
`else
      err = 1;
`endif
    end
    for (int i = 0; i <= len; i++) begin
      if (err) begin
        exp_q.push_back('{32'd0, 2'b10, i == len, id});
      end else begin
        if (burst == 0) a = word;
        else if (burst == 1) a = word + i;
        else begin
          base = word - (word % (len + 1));
          a    = base + ((word - base + i) % (len + 1));
        end
        exp_addr_q.push_back(a);
        exp_q.push_back('{mem_model[a], 2'b00, i == len, id});
      end
    end
  endfunction

  task automatic issue_ar(input logic [3:0] id, input int addr, input int len,
                          input int size, input int burst);
    bit hs = 0;
    @(posedge clk); #1;
    bus.arid    = id;
    bus.araddr  = 16'(addr);
    bus.arlen   = 8'(len);
    bus.arsize  = 3'(size);
    bus.arburst = 2'(burst);
    bus.arvalid = 1'b1;
    for (int n = 0; n < 300 && !hs; n++) begin
      @(negedge clk);
      if (bus.arready) begin
        model_burst(id, addr, len, size, burst);
        hs = 1;
      end
    end
    if (!hs) begin
      checks++; errors++;
      $display("FAIL ar_handshake: got no arready within 300 cycles, required arready=1");
    end
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_beats_left"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_addrs_left"}, 64'(exp_addr_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    $display("burst %s finished after %0d cycles", tag, n);
  endtask

  // Monitor: compares every R beat and memory access against the scoreboard queues.
  initial begin
    bit          prev_stall = 0;
    logic [34:0] prev_bits = '0;
    bit          lat_armed = 0;
    int          lat_cnt = 0;
    int          issued_n = 0, consumed_n = 0;
    logic [9:0]  last_mem_addr = '0;
    bit          pop;
    beat_t       e;
    int          ea;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 0; lat_armed = 0; issued_n = 0; consumed_n = 0; last_mem_addr = '0;
      end else begin
        pop = bus.rvalid && bus.rready;
        if (prev_stall) begin
          check("stall_rvalid_held", 64'(bus.rvalid), 64'd1);
          check("stall_payload_held", 64'({bus.rdata, bus.rresp, bus.rlast}), 64'(prev_bits));
        end
        if (lat_armed) begin
          lat_cnt++;
          if (bus.rvalid) begin
            lat_armed = 0;
            if (exp_q.size() > 0 && exp_q[0].resp == 2'b00)
              check("first_rvalid_latency", 64'(lat_cnt), 64'd3);
          end
        end
        if (bus.mem_en) begin
          check("outstanding_below_2", 64'((issued_n - consumed_n - int'(pop)) < 2), 64'd1);
          if (exp_addr_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL mem_en_unexpected: got mem_en=1 addr=%0d, required no access", bus.mem_addr);
          end else begin
            ea = exp_addr_q.pop_front();
            check("mem_addr", 64'(bus.mem_addr), 64'(ea));
          end
          last_mem_addr = bus.mem_addr;
          issued_n++;
        end else begin
          check("mem_addr_hold", 64'(bus.mem_addr), 64'(last_mem_addr));
        end
        if (pop) begin
          consumed_n++;
          beats_seen++;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL r_beat_unexpected: got beat data=%0h, required none", bus.rdata);
          end else begin
            e = exp_q.pop_front();
            check("rdata", 64'(bus.rdata), 64'(e.data));
            check("rresp", 64'(bus.rresp), 64'(e.resp));
            check("rlast", 64'(bus.rlast), 64'(e.last));
            check("rid", 64'(bus.rid), 64'(e.id));
          end
        end
        prev_stall = bus.rvalid && !bus.rready;
        prev_bits  = {bus.rdata, bus.rresp, bus.rlast};
        if (bus.arvalid && bus.arready) begin
          lat_armed = 1; lat_cnt = 0; issued_n = 0; consumed_n = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      case (rr_mode)
        0:       bus.rready = 1'b1;
        1:       bus.rready = ~bus.rready;
        default: bus.rready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    int n;
    for (int i = 0; i < 1024; i++) mem_model[i] = $urandom;
    for (int i = 0; i < 4; i++) mem_model[4 + i] = 32'hA0 + i;
    bus.arvalid = 0; bus.arid = 0; bus.araddr = 0; bus.arlen = 0;
    bus.arsize = 0; bus.arburst = 0; bus.rready = 1;

    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({bus.arready, bus.rvalid, bus.rlast, bus.rresp, bus.rid,
                                bus.rdata, bus.mem_en, bus.mem_addr}), 64'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    #1 check("arready_before_first_edge", 64'(bus.arready), 64'd0);
    @(posedge clk); @(negedge clk);
    check("arready_after_release", 64'(bus.arready), 64'd1);

    rr_mode = 0;
    issue_ar(4'h3, 'h0010, 3, 2, 1);  wait_done("incr_basic");
    rr_mode = 1;
    issue_ar(4'h5, 'h0100, 7, 2, 1);  wait_done("incr_backpressure");
    rr_mode = 0;
    issue_ar(4'h6, 'h0020, 2, 2, 0);  wait_done("fixed");
    issue_ar(4'h7, 'h0010, 3, 3, 1);  wait_done("err_size");
    issue_ar(4'h8, 'h0010, 3, 2, 3);  wait_done("err_burst11");
    issue_ar(4'h9, 'h0FF8, 3, 2, 1);  wait_done("err_depth_end");
    issue_ar(4'hA, 'h0018, 3, 2, 2);  wait_done("wrap");

    rr_mode = 2;
    for (int k = 0; k < 25; k++) begin
      int addr = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 4095))
                                              : int'($urandom_range(0, 65535));
      int size = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : 2;
      issue_ar(4'($urandom), addr, int'($urandom_range(0, 15)), size,
               int'($urandom_range(0, 3)));
      wait_done("random");
    end

    rr_mode = 0;
    beats_seen = 0;
    issue_ar(4'hC, 'h0200, 7, 2, 1);
    n = 0;
    while (beats_seen < 2 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("reached_beat_2", 64'(beats_seen >= 2), 64'd1);
    #2 rst_n = 1'b0;
    #1 check("midburst_reset_outputs", 64'({bus.arready, bus.rvalid, bus.rlast, bus.rresp, bus.rid,
                                            bus.rdata, bus.mem_en, bus.mem_addr}), 64'd0);
    exp_q.delete();
    exp_addr_q.delete();
    repeat (2) @(negedge clk);
    check("no_beats_in_reset", 64'(bus.rvalid), 64'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    #1 check("arready_before_edge_2", 64'(bus.arready), 64'd0);
    @(posedge clk); @(negedge clk);
    check("arready_after_release_2", 64'(bus.arready), 64'd1);
    issue_ar(4'hD, 'h0040, 5, 2, 1);  wait_done("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
